mem_port_arbiter_2x1: RTL and testbench
=======================================

// Module: mem_port_arbiter_2x1
// PURPOSE
//  Shares one 32-bit memory port between two requesters: port 0 (instruction fetch) and port 1 (data load/store).
//  Round-robin arbitration. Grant is held until the memory acknowledges or the watchdog expires.
//  The registered owner drives sel, which steers the addr/wdata 2:1 32-bit mux toward memory.
//  One transaction is outstanding at a time. Sits between the fetch/mem stages and the memory model.
// PARAMETERS
//  WIDTH    32  data/address width
//  TIMEOUT  64  BUSY cycles without mem_ack before abort; 0 disables the watchdog
//  CNT_W    8   watchdog counter width; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  req0/req1  in   1      level request, held until ackN/errN
//  addr0/addr1  in WIDTH  request address
//  wdata0/wdata1 in WIDTH write data
//  we0/we1    in   1      1 = write, 0 = read
//  ack0/ack1  out  1      one-cycle completion pulse to the owner
//  err0/err1  out  1      one-cycle timeout pulse to the owner
//  rdata      out  WIDTH  registered read data, valid while ackN=1
//  sel        out  1      current/last owner (0 = port0, 1 = port1)
//  mem_req    out  1      memory request, level
//  mem_we     out  1      registered write enable
//  mem_addr   out  WIDTH  registered address
//  mem_wdata  out  WIDTH  registered write data
//  mem_ack    in   1      memory completion, sampled only in BUSY
//  mem_rdata  in   WIDTH  memory read data, valid with mem_ack
// BEHAVIOUR
//  Reset (async, any state, mid-transaction included):
//   - state=IDLE; all outputs 0; sel=0; counter=0; last=1, so port0 wins the first tie.
//   - An aborted memory access is dropped and no ack/err is issued.
//  FSM: IDLE -> BUSY -> RESP -> IDLE.
//  IDLE
//   - If no req, stay in IDLE.
//   - Single req: grant that port.
//   - Both req: grant !last.
//   - On grant, at the same edge: sel<=grant; last<=grant; latch addr/wdata/we of the granted port into mem_*; mem_req<=1; -> BUSY.
//   - Latency: mem_req rises 1 cycle after req is sampled.
//  BUSY
//   - mem_req=1; mem_addr, mem_wdata, mem_we and sel stay stable; counter increments each cycle.
//   - mem_ack=1: rdata<=mem_rdata (0 on writes); ack[sel]<=1; mem_req<=0; -> RESP.
//   - Else, if TIMEOUT!=0 and counter==TIMEOUT-1: err[sel]<=1; rdata<=0; mem_req<=0; -> RESP.
//   - mem_ack on the same cycle as expiry: ack wins and err stays 0.
//   - Owner dropping req while in BUSY: the transaction still completes and ack still pulses.
//   - Requests from the other port are ignored and stay pending until IDLE.
//  RESP
//   - ackN/errN high for exactly this cycle; counter<=0; -> IDLE.
//   - The requester drops req on the edge that samples ack.
//   - A req still high in IDLE is treated as a new request.
//  Throughput: at least 3 cycles per transaction (IDLE, BUSY, RESP).
//  Back-to-back requests from both ports alternate 0,1,0,1.
//  Invariants:
//   - mem_req is never high outside BUSY.
//   - ack0, ack1, err0 and err1 are mutually exclusive.
//   - sel changes only on the IDLE->BUSY edge.
//  mem_ack outside BUSY is ignored.
// TESTING
//  1. Reset, then hold req0=1, addr0=0x0040, we0=0; mem_ack on the 2nd BUSY cycle with mem_rdata=0xDEADBEEF
//     -> mem_req high for 2 cycles, mem_addr=0x0040, sel=0, ack0 for 1 cycle with rdata=0xDEADBEEF.
//  2. req0 and req1 rise in the same cycle and are held; memory acks after 1 cycle
//     -> grants 0,1,0,1 in order; sel toggles; ack0 and ack1 never overlap.
//  3. req1=1, we1=1, addr1=0x1000, wdata1=0x12345678; memory never acks; TIMEOUT=4
//     -> mem_req high for 4 cycles, then err1 pulses once, rdata=0, ack1 stays 0.
//  4. TIMEOUT=4 and mem_ack asserted exactly on the 4th BUSY cycle -> ack pulses, err stays 0.
//  5. Drive rst_n=0 during BUSY
//     -> mem_req, sel and all acks go to 0 immediately; after release, a tie grants port0 first.
//  6. req0 drops in mid-BUSY; change addr0 during BUSY
//     -> mem_addr stays at the latched value; ack0 still pulses; a pending req1 is granted next.

Source files
------------

// File: rtl/mem_port_arbiter_2x1.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter_2x1
// Round-robin 2:1 arbiter sharing one memory port, with a BUSY-state watchdog.
// Rev    : 1.0
// ============================================================================
module mem_port_arbiter_2x1 #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] addr0,
    input  logic [WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    input  logic             we0,
    input  logic             we1,
    output logic             ack0,
    output logic             ack1,
    output logic             err0,
    output logic             err1,
    output logic [WIDTH-1:0] rdata,
    output logic             sel,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t             state_q,     state_d;
    logic               last_q,      last_d;
    logic               sel_q,       sel_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               mem_req_q,   mem_req_d;
    logic               mem_we_q,    mem_we_d;
    logic [WIDTH-1:0]   mem_addr_q,  mem_addr_d;
    logic [WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [WIDTH-1:0]   rdata_q,     rdata_d;
    logic [1:0]         ack_q,       ack_d;
    logic [1:0]         err_q,       err_d;
    logic               grant;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        ack_d       = 2'b00;
        err_d       = 2'b00;
        grant       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the port that did not win last time goes next.
                    grant       = (req0 && req1) ? ~last_q : req1;
                    sel_d       = grant;
                    last_d      = grant;
                    mem_addr_d  = grant ? addr1  : addr0;
                    mem_wdata_d = grant ? wdata1 : wdata0;
                    mem_we_d    = grant ? we1    : we0;
                    mem_req_d   = 1'b1;
                    cnt_d       = '0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_ack) begin
                    rdata_d       = mem_we_q ? '0 : mem_rdata;
                    ack_d[sel_q]  = 1'b1;
                    mem_req_d     = 1'b0;
                    state_d       = RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == c_cnt_last)) begin
                    rdata_d       = '0;
                    err_d[sel_q]  = 1'b1;
                    mem_req_d     = 1'b0;
                    state_d       = RESP;
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            sel_q       <= 1'b0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            ack_q       <= 2'b00;
            err_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
        end
    end

    assign ack0      = ack_q[0];
    assign ack1      = ack_q[1];
    assign err0      = err_q[0];
    assign err1      = err_q[1];
    assign rdata     = rdata_q;
    assign sel       = sel_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter_2x1.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_port_arbiter_2x1
// Directed and randomized transactions against a transaction-level model.
// Rev    : 1.0
// ============================================================================
module tb_mem_port_arbiter_2x1;

    localparam int W  = 32;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0, req1, we0, we1, mem_ack;
    logic [W-1:0] addr0, addr1, wdata0, wdata1, mem_rdata;
    logic         ack0, ack1, err0, err1, sel, mem_req, mem_we;
    logic [W-1:0] rdata, mem_addr, mem_wdata;

    always #5 clk = ~clk;

    mem_port_arbiter_2x1 #(.WIDTH(W), .TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .we0(we0), .we1(we1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata(rdata), .sel(sel),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    int checks   = 0;
    int failures = 0;

    // Requester-side model: pending flags and the request each port is holding.
    bit           pend [2];
    logic [W-1:0] a    [2];
    logic [W-1:0] wd   [2];
    bit           w    [2];
    bit           m_last;
    bit           exp_sel;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_port(input bit p);
        if (!p) begin
            req0 = pend[0]; addr0 = a[0]; wdata0 = wd[0]; we0 = w[0];
        end else begin
            req1 = pend[1]; addr1 = a[1]; wdata1 = wd[1]; we1 = w[1];
        end
    endtask

    task automatic new_req_v(input bit p, input logic [W-1:0] ad, input logic [W-1:0] dat, input bit wr);
        pend[p] = 1'b1; a[p] = ad; wd[p] = dat; w[p] = wr;
    endtask

    task automatic new_req(input bit p);
        new_req_v(p, $urandom, $urandom, 1'($urandom_range(0, 1)));
    endtask

    task automatic pulses_zero(input string tag);
        chk(tag, 32'({ack0, ack1, err0, err1}), 32'd0);
    endtask

    // One full transaction starting from IDLE; d = BUSY cycle on which memory acks.
    task automatic txn(input int d, input logic [W-1:0] rd, input bit drop, input bit scramble,
                       input bit raise_other, output bit owner);
        bit           o, ok, ewe;
        int           n;
        logic [W-1:0] ea, ewd;
        o   = (pend[0] && pend[1]) ? ~m_last : pend[1];
        ea  = a[o]; ewd = wd[o]; ewe = w[o];
        ok  = (d <= TO);
        n   = ok ? d : TO;
        drive_port(1'b0); drive_port(1'b1);
        tick();
        m_last = o; exp_sel = o; owner = o;
        for (int k = 1; k <= n; k++) begin
            chk("busy_mem_req", 32'(mem_req), 32'd1);
            chk("busy_sel",     32'(sel), 32'(o));
            chk("busy_addr",    mem_addr, ea);
            chk("busy_wdata",   mem_wdata, ewd);
            chk("busy_we",      32'(mem_we), 32'(ewe));
            pulses_zero("busy_pulses");
            mem_ack   = (k == d);
            mem_rdata = (k == d) ? rd : $urandom;
            if (drop && k == 1) begin
                pend[o] = 1'b0;
                drive_port(o);
            end
            if (scramble) begin
                if (!o) begin addr0 = $urandom; wdata0 = $urandom; we0 = 1'($urandom_range(0, 1)); end
                else    begin addr1 = $urandom; wdata1 = $urandom; we1 = 1'($urandom_range(0, 1)); end
            end
            if (raise_other && !pend[~o]) begin
                new_req(~o);
                drive_port(~o);
            end
            tick();
        end
        chk("resp_mem_req", 32'(mem_req), 32'd0);
        chk("resp_pulses", 32'({ack0, ack1, err0, err1}),
            32'({ok && !o, ok && o, !ok && !o, !ok && o}));
        chk("resp_rdata", rdata, (ok && !ewe) ? rd : 32'd0);
        pend[o] = 1'b0;
        drive_port(o);
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        tick();
        pulses_zero("idle_pulses");
        chk("idle_mem_req", 32'(mem_req), 32'd0);
        chk("idle_sel",     32'(sel), 32'(exp_sel));
        mem_ack = 1'b0;
    endtask

    task automatic idle_cycle();
        drive_port(1'b0); drive_port(1'b1);
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        tick();
        chk("noreq_mem_req", 32'(mem_req), 32'd0);
        chk("noreq_sel",     32'(sel), 32'(exp_sel));
        pulses_zero("noreq_pulses");
        mem_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        drive_port(1'b0); drive_port(1'b1);
        mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req",   32'(mem_req), 32'd0);
        chk("rst_sel",       32'(sel), 32'd0);
        pulses_zero("rst_pulses");
        chk("rst_rdata",     rdata, 32'd0);
        chk("rst_mem_addr",  mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_we",    32'(mem_we), 32'd0);
        m_last  = 1'b1;
        exp_sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        bit own;
        rst_n = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; a[p] = '0; wd[p] = '0; w[p] = 1'b0;
        end
        #1;
        do_reset();

        // Single read from port 0, memory acks on the 2nd BUSY cycle.
        new_req_v(1'b0, 32'h0000_0040, 32'h0, 1'b0);
        txn(2, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, own);
        chk("t1_owner", 32'(own), 32'd0);

        // Write from port 1 that memory never acks: watchdog error.
        new_req_v(1'b1, 32'h0000_1000, 32'h1234_5678, 1'b1);
        txn(7, 32'h0, 1'b0, 1'b0, 1'b0, own);
        chk("t3_owner", 32'(own), 32'd1);

        // Ack on the very cycle the watchdog would expire.
        new_req(1'b0);
        txn(TO, $urandom, 1'b0, 1'b0, 1'b0, own);

        // Owner drops req and changes addr mid-BUSY; port 1 arrives and goes next.
        new_req(1'b0);
        txn(3, $urandom, 1'b1, 1'b1, 1'b1, own);
        chk("t6_first",  32'(own), 32'd0);
        txn(1, $urandom, 1'b0, 1'b0, 1'b0, own);
        chk("t6_second", 32'(own), 32'd1);

        // Both ports held continuously: grants alternate starting with port 0.
        do_reset();
        new_req(1'b0);
        new_req(1'b1);
        for (int i = 0; i < 4; i++) begin
            txn(1, $urandom, 1'b0, 1'b0, 1'b0, own);
            chk("t2_order", 32'(own), 32'(i % 2));
            if (i < 2) new_req(own);
        end

        // Reset asserted mid-BUSY clears outputs immediately.
        new_req(1'b1);
        drive_port(1'b0); drive_port(1'b1);
        tick();
        chk("t5_busy", 32'(mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_mem_req", 32'(mem_req), 32'd0);
        chk("t5_sel",     32'(sel), 32'd0);
        pulses_zero("t5_pulses");
        do_reset();
        new_req(1'b0);
        new_req(1'b1);
        txn(1, $urandom, 1'b0, 1'b0, 1'b0, own);
        chk("t5_tie_first", 32'(own), 32'd0);
        txn(2, $urandom, 1'b0, 1'b0, 1'b0, own);
        chk("t5_tie_second", 32'(own), 32'd1);

        // Randomized traffic.
        for (int it = 0; it < 80; it++) begin
            for (int p = 0; p < 2; p++)
                if (!pend[p] && ($urandom_range(0, 2) != 0)) new_req(p[0]);
            if (!pend[0] && !pend[1])
                idle_cycle();
            else
                txn($urandom_range(1, TO + 2), $urandom, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, own);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
